// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
//
// Sequencing FSM for a 2-way, 8-set, 32-byte-line, write-back /
// write-allocate L1 cache datapath. Handles one CPU access at a time:
// tag check, LRU update, dirty-victim writeback and line fill over the
// 256-bit physical-memory port.
//
// Optional feature macro: CACHE_PERF_CNT_EN
//   defined   : perf_hits / perf_misses / perf_writebacks count events
//   undefined : the three perf ports are tied to 0, no counter flops
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mem_read, mem_write          CPU request (held until mem_resp)
//   mem_byte_enable[3:0]         CPU write byte mask
//   mem_offset[s_offset-1:0]     byte offset within the line
//   mem_resp                     one-cycle CPU completion pulse
//   pmem_read, pmem_write        memory request, held until pmem_resp
//   pmem_resp                    memory completion pulse
//   hit1/2, valid1/2, dirty1/2   datapath status per way
//   lru_out                      0 = way 1 is LRU
//   data_r*, read_*              array read enables (always 1)
//   data_w1/2[s_mask-1:0]        per-byte data-array write enables
//   load_tag*/valid*/dirty*/lru  array loads
//   valid_in, dirty_in, lru_in   array write data
//   data_sel                     0 = pmem_rdata, 1 = CPU-merged line
//   path_sel                     0 = way 1, 1 = way 2
//   pmem_sel[1:0]                0 = CPU line, 1 = way-1 tag, 2 = way-2 tag
//   load_pmem_wdata              latch victim line for writeback
//   perf_*[31:0]                 event counters
//   dbg_state[2:0]               current FSM state (debug observation)
//
// Handshake: the CPU holds mem_read/mem_write, address and data stable
// until it sees mem_resp high for one cycle, then drops or changes the
// request; a request still present in the following IDLE cycle is a new
// access. pmem_read/pmem_write are held from state entry through the
// cycle in which pmem_resp is high.
// ---------------------------------------------------------------------------
module cache_control #(
  parameter int s_offset = 5,
  parameter int s_mask   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [3:0]          mem_byte_enable,
  input  logic [s_offset-1:0] mem_offset,
  output logic                mem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  input  logic                hit1,
  input  logic                hit2,
  input  logic                valid1,
  input  logic                valid2,
  input  logic                dirty1,
  input  logic                dirty2,
  input  logic                lru_out,
  output logic                data_r1,
  output logic                data_r2,
  output logic                read_tag1,
  output logic                read_tag2,
  output logic                read_valid1,
  output logic                read_valid2,
  output logic                read_dirty1,
  output logic                read_dirty2,
  output logic [s_mask-1:0]   data_w1,
  output logic [s_mask-1:0]   data_w2,
  output logic                load_tag1,
  output logic                load_tag2,
  output logic                load_valid1,
  output logic                load_valid2,
  output logic                load_dirty1,
  output logic                load_dirty2,
  output logic                load_lru,
  output logic                valid_in,
  output logic                dirty_in,
  output logic                lru_in,
  output logic                data_sel,
  output logic                path_sel,
  output logic [1:0]          pmem_sel,
  output logic                load_pmem_wdata,
  output logic [31:0]         perf_hits,
  output logic [31:0]         perf_misses,
  output logic [31:0]         perf_writebacks,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WB_LATCH  = 3'd2,
    S_WRITEBACK = 3'd3,
    S_ALLOCATE  = 3'd4
  } state_t;

  state_t state_q;
  logic   victim_q;   // 0 = way 1, 1 = way 2; frozen for the whole miss

  logic              hit_any;
  logic              lru_victim_dirty;
  logic [s_mask-1:0] cpu_wmask;

  assign hit_any          = hit1 | hit2;
  assign lru_victim_dirty = lru_out ? (valid2 & dirty2) : (valid1 & dirty1);

  // Byte enables of the 32-bit CPU word placed at its word slot in the line.
  assign cpu_wmask = {{(s_mask-4){1'b0}}, mem_byte_enable}
                     << {mem_offset[s_offset-1:2], 2'b00};

  // Low offset bits only matter to the datapath's byte steering.
  logic unused_offset_bits;
  assign unused_offset_bits = ^mem_offset[1:0];

  // Arrays are read every cycle.
  assign data_r1     = 1'b1;
  assign data_r2     = 1'b1;
  assign read_tag1   = 1'b1;
  assign read_tag2   = 1'b1;
  assign read_valid1 = 1'b1;
  assign read_valid2 = 1'b1;
  assign read_dirty1 = 1'b1;
  assign read_dirty2 = 1'b1;

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      victim_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_read | mem_write) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (hit_any) begin
            state_q <= S_IDLE;
          end else begin
            victim_q <= lru_out;
            state_q  <= lru_victim_dirty ? S_WB_LATCH : S_ALLOCATE;
          end
        end
        S_WB_LATCH: begin
          state_q <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (pmem_resp) state_q <= S_ALLOCATE;
        end
        S_ALLOCATE: begin
          if (pmem_resp) state_q <= S_CHECK;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the registered state: the array status only
  // becomes valid in CHECK, so the hit response must be formed in that same
  // cycle. Everything is forced quiet while rst is high so that no array
  // load or response can slip out of an aborted access.
  always_comb begin
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    data_w1         = '0;
    data_w2         = '0;
    load_tag1       = 1'b0;
    load_tag2       = 1'b0;
    load_valid1     = 1'b0;
    load_valid2     = 1'b0;
    load_dirty1     = 1'b0;
    load_dirty2     = 1'b0;
    load_lru        = 1'b0;
    valid_in        = 1'b0;
    dirty_in        = 1'b0;
    lru_in          = 1'b0;
    data_sel        = 1'b0;
    path_sel        = 1'b0;
    pmem_sel        = 2'd0;
    load_pmem_wdata = 1'b0;
    if (!rst) begin
      case (state_q)
        S_CHECK: begin
          if (hit_any) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            // Way 1 wins if both hit; the way not used becomes LRU.
            lru_in   = hit1;
            path_sel = ~hit1;
            if (mem_write) begin
              data_sel = 1'b1;
              dirty_in = 1'b1;
              if (hit1) begin
                data_w1     = cpu_wmask;
                load_dirty1 = 1'b1;
              end else begin
                data_w2     = cpu_wmask;
                load_dirty2 = 1'b1;
              end
            end
          end
        end
        S_WB_LATCH: begin
          path_sel        = victim_q;
          load_pmem_wdata = 1'b1;
        end
        S_WRITEBACK: begin
          pmem_write = 1'b1;
          pmem_sel   = victim_q ? 2'd2 : 2'd1;
        end
        S_ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            valid_in = 1'b1;
            if (victim_q) begin
              data_w2     = '1;
              load_tag2   = 1'b1;
              load_valid2 = 1'b1;
              load_dirty2 = 1'b1;
            end else begin
              data_w1     = '1;
              load_tag1   = 1'b1;
              load_valid1 = 1'b1;
              load_dirty1 = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;
  logic [31:0] wbs_q;
  logic        after_alloc_q;  // this CHECK re-checks a just-filled line

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q        <= '0;
      misses_q      <= '0;
      wbs_q         <= '0;
      after_alloc_q <= 1'b0;
    end else begin
      if (state_q == S_CHECK && hit_any && !after_alloc_q) hits_q <= hits_q + 32'd1;
      if (state_q == S_CHECK && !hit_any) misses_q <= misses_q + 32'd1;
      if (state_q == S_WRITEBACK && pmem_resp) wbs_q <= wbs_q + 32'd1;
      after_alloc_q <= (state_q == S_ALLOCATE) && pmem_resp;
    end
  end

  assign perf_hits       = hits_q;
  assign perf_misses     = misses_q;
  assign perf_writebacks = wbs_q;
`else
  assign perf_hits       = 32'd0;
  assign perf_misses     = 32'd0;
  assign perf_writebacks = 32'd0;
`endif

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

  // -------------------------------------------------------------------------
  // clock / reset
  // -------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CACHE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CHECK     = 3'd1;
  localparam logic [2:0] ST_WB_LATCH  = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_ALLOCATE  = 3'd4;

  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [4:0]  mem_offset;
  logic        mem_resp;
  logic        pmem_read, pmem_write, pmem_resp;
  logic        hit1, hit2, valid1, valid2, dirty1, dirty2, lru_out;
  logic        data_r1, data_r2, read_tag1, read_tag2;
  logic        read_valid1, read_valid2, read_dirty1, read_dirty2;
  logic [31:0] data_w1, data_w2;
  logic        load_tag1, load_tag2, load_valid1, load_valid2;
  logic        load_dirty1, load_dirty2, load_lru;
  logic        valid_in, dirty_in, lru_in, data_sel, path_sel;
  logic [1:0]  pmem_sel;
  logic        load_pmem_wdata;
  logic [31:0] perf_hits, perf_misses, perf_writebacks;
  logic [2:0]  dbg_state;

  cache_control dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_offset(mem_offset),
    .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit1(hit1), .hit2(hit2), .valid1(valid1), .valid2(valid2),
    .dirty1(dirty1), .dirty2(dirty2), .lru_out(lru_out),
    .data_r1(data_r1), .data_r2(data_r2),
    .read_tag1(read_tag1), .read_tag2(read_tag2),
    .read_valid1(read_valid1), .read_valid2(read_valid2),
    .read_dirty1(read_dirty1), .read_dirty2(read_dirty2),
    .data_w1(data_w1), .data_w2(data_w2),
    .load_tag1(load_tag1), .load_tag2(load_tag2),
    .load_valid1(load_valid1), .load_valid2(load_valid2),
    .load_dirty1(load_dirty1), .load_dirty2(load_dirty2),
    .load_lru(load_lru),
    .valid_in(valid_in), .dirty_in(dirty_in), .lru_in(lru_in),
    .data_sel(data_sel), .path_sel(path_sel), .pmem_sel(pmem_sel),
    .load_pmem_wdata(load_pmem_wdata),
    .perf_hits(perf_hits), .perf_misses(perf_misses),
    .perf_writebacks(perf_writebacks),
    .dbg_state(dbg_state)
  );

  // -------------------------------------------------------------------------
  // scoreboard
  // -------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // expected write-hit byte masks, in request order

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pop the next expected mask and compare it with the observed one
  task automatic chk_mask(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      chk(tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  // -------------------------------------------------------------------------
  // driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_req(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [4:0] off);
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_offset      = off;
  endtask

  task automatic cpu_idle();
    cpu_req(1'b0, 1'b0, 4'h0, 5'h00);
  endtask

  task automatic set_status(input logic h1, input logic h2, input logic v1,
                            input logic v2, input logic d1, input logic d2,
                            input logic lru);
    hit1 = h1; hit2 = h2; valid1 = v1; valid2 = v2;
    dirty1 = d1; dirty2 = d2; lru_out = lru;
  endtask

  // -------------------------------------------------------------------------
  // directed sequence
  // -------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    pmem_resp = 1'b0;
    cpu_idle();
    set_status(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_mem_resp", 32'(mem_resp), 0);
    chk("rst_pmem", {30'd0, pmem_read, pmem_write}, 0);
    chk("rst_read_en", {24'd0, data_r1, data_r2, read_tag1, read_tag2,
                        read_valid1, read_valid2, read_dirty1, read_dirty2}, 32'hFF);
    chk("rst_loads", {25'd0, load_tag1, load_tag2, load_valid1, load_valid2,
                      load_dirty1, load_dirty2, load_lru}, 0);
    chk("rst_dataw", data_w1 | data_w2, 0);
    chk("rst_perf", perf_hits | perf_misses | perf_writebacks, 0);

    // ---- cold read miss, fill way 1 ----
    cpu_req(1, 0, 4'h0, 5'h00);
    #1;
    chk("cold_idle_resp", 32'(mem_resp), 0);
    tick();
    chk("cold_state_check", 32'(dbg_state), 32'(ST_CHECK));
    chk("cold_check_noresp", {30'd0, mem_resp, load_lru}, 0);
    tick();
    chk("cold_state_alloc", 32'(dbg_state), 32'(ST_ALLOCATE));
    chk("cold_alloc_rd", {29'd0, pmem_read, pmem_write, 1'b0}, 32'h4);
    chk("cold_alloc_sel", 32'(pmem_sel), 0);
    chk("cold_alloc_nofill", data_w1, 0);
    tick();
    chk("cold_alloc_hold", 32'(pmem_read), 1);
    pmem_resp = 1'b1;
    #1;
    chk("cold_fill_w1", data_w1, 32'hFFFFFFFF);
    chk("cold_fill_w2", data_w2, 0);
    chk("cold_fill_loads", {26'd0, load_tag1, load_valid1, load_dirty1,
                            load_tag2, load_valid2, load_dirty2}, 32'h38);
    chk("cold_fill_vin_din_sel", {29'd0, valid_in, dirty_in, data_sel}, 32'h4);
    tick();
    pmem_resp = 1'b0;
    set_status(1, 0, 1, 0, 0, 0, 0);
    #1;
    chk("cold_recheck_state", 32'(dbg_state), 32'(ST_CHECK));
    chk("cold_recheck_resp", 32'(mem_resp), 1);
    chk("cold_recheck_lru", {30'd0, load_lru, lru_in}, 32'h3);
    tick();
    cpu_idle();
    set_status(0, 0, 1, 0, 0, 0, 1);
    #1;
    chk("cold_after_resp", 32'(mem_resp), 0);
    chk("cold_perf_misses", perf_misses, pexp(1));
    chk("cold_perf_hits", perf_hits, pexp(0));

    // ---- read hit in way 1 ----
    cpu_req(1, 0, 4'h0, 5'h04);
    tick();
    set_status(1, 0, 1, 0, 0, 0, 1);
    #1;
    chk("rhit_resp", 32'(mem_resp), 1);
    chk("rhit_lru", {30'd0, load_lru, lru_in}, 32'h3);
    chk("rhit_path", 32'(path_sel), 0);
    chk("rhit_no_pmem", {30'd0, pmem_read, pmem_write}, 0);
    chk("rhit_no_write", data_w1 | data_w2, 0);
    tick();
    cpu_idle();
    #1;
    chk("rhit_idle", {29'd0, dbg_state}, 32'(ST_IDLE));
    chk("rhit_perf_hits", perf_hits, pexp(1));

    // ---- write hit in way 2, be=0011, offset 0x0C ----
    cpu_req(0, 1, 4'b0011, 5'h0C);
    exp_q.push_back(32'h00003000);
    tick();
    set_status(0, 1, 1, 1, 0, 0, 0);
    #1;
    chk_mask("whit_w2", data_w2);
    chk("whit_w1", data_w1, 0);
    chk("whit_dirty", {29'd0, load_dirty2, load_dirty1, dirty_in}, 32'h5);
    chk("whit_lru_path_sel", {28'd0, lru_in, path_sel, data_sel, mem_resp}, 32'h7);
    tick();
    cpu_idle();
    #1;
    chk("whit_perf_hits", perf_hits, pexp(2));

    // ---- dirty miss, way 2 is LRU and dirty ----
    cpu_req(1, 0, 4'h0, 5'h00);
    tick();
    set_status(0, 0, 1, 1, 0, 1, 1);
    #1;
    chk("dmiss_check_noresp", 32'(mem_resp), 0);
    tick();
    set_status(0, 0, 1, 1, 0, 1, 0);   // LRU moves; victim must not follow
    #1;
    chk("dmiss_wblatch_state", 32'(dbg_state), 32'(ST_WB_LATCH));
    chk("dmiss_wblatch", {30'd0, load_pmem_wdata, path_sel}, 32'h3);
    chk("dmiss_wblatch_nopmem", {30'd0, pmem_read, pmem_write}, 0);
    tick();
    chk("dmiss_wb_state", 32'(dbg_state), 32'(ST_WRITEBACK));
    chk("dmiss_wb_pmem", {30'd0, pmem_read, pmem_write}, 32'h1);
    chk("dmiss_wb_sel", 32'(pmem_sel), 2);
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("dmiss_wb_resp_hold", {29'd0, pmem_write, pmem_sel}, 32'h6);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("dmiss_alloc_state", 32'(dbg_state), 32'(ST_ALLOCATE));
    chk("dmiss_alloc_pmem", {28'd0, pmem_read, pmem_write, pmem_sel}, 32'h8);
    chk("dmiss_perf_wb", perf_writebacks, pexp(1));
    chk("dmiss_perf_misses", perf_misses, pexp(2));
    pmem_resp = 1'b1;
    #1;
    chk("dmiss_fill_w2", data_w2, 32'hFFFFFFFF);
    chk("dmiss_fill_w1", data_w1, 0);
    chk("dmiss_fill_loads", {29'd0, load_tag2, load_valid2, load_dirty2}, 32'h7);
    tick();
    pmem_resp = 1'b0;
    set_status(0, 1, 1, 1, 0, 0, 0);
    #1;
    chk("dmiss_recheck", {29'd0, mem_resp, path_sel, lru_in}, 32'h6);
    tick();
    cpu_idle();
    #1;
    chk("dmiss_perf_hits", perf_hits, pexp(2));

    // ---- read+write together, both hits set: a write to way 1 ----
    cpu_req(1, 1, 4'b1111, 5'h00);
    exp_q.push_back(32'h0000000F);
    tick();
    set_status(1, 1, 1, 1, 0, 0, 0);
    #1;
    chk_mask("rw_w1", data_w1);
    chk("rw_w2", data_w2, 0);
    chk("rw_lru_path", {29'd0, lru_in, path_sel, load_dirty1}, 32'h5);
    tick();
    cpu_idle();
    #1;
    chk("rw_perf_hits", perf_hits, pexp(3));

    // ---- reset during WRITEBACK (way 1 victim) ----
    cpu_req(1, 0, 4'h0, 5'h00);
    tick();
    set_status(0, 0, 1, 1, 1, 0, 0);
    tick();
    #1;
    chk("rwb_wblatch", {29'd0, load_pmem_wdata, path_sel, 1'b0}, 32'h4);
    tick();
    chk("rwb_wb", {29'd0, pmem_write, pmem_sel}, 32'h5);
    rst = 1'b1;
    cpu_idle();
    #1;
    chk("rwb_rst_noresp", 32'(mem_resp), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rwb_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rwb_pmem_drop", {30'd0, pmem_read, pmem_write}, 0);
    chk("rwb_noresp", 32'(mem_resp), 0);
    chk("rwb_perf_clear", perf_hits | perf_misses | perf_writebacks, 0);

    // ---- reset in the ALLOCATE pmem_resp cycle: no array load ----
    cpu_req(1, 0, 4'h0, 5'h00);
    set_status(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("ralloc_state", 32'(dbg_state), 32'(ST_ALLOCATE));
    rst = 1'b1;
    pmem_resp = 1'b1;
    cpu_idle();
    #1;
    chk("ralloc_no_load", {29'd0, load_tag1, load_valid1, load_dirty1}, 0);
    chk("ralloc_no_write", data_w1 | data_w2, 0);
    tick();
    rst = 1'b0;
    pmem_resp = 1'b0;
    #1;
    chk("ralloc_idle", {28'd0, pmem_read, dbg_state}, 32'(ST_IDLE));
    chk("exp_q_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // safety net so the run always ends on its own
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
